// File: rtl/uart_echo_checker_pkg.sv
// rtl/uart_echo_checker_pkg.sv - 8N1 frame constants, FSM encoding and bit-time derivation
package uart_echo_checker_pkg;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ECHO,
    ST_CHECK,
    ST_FIN
  } state_e;

  // Clocks per bit, integer divide, shared by the TX shifter and RX sampler.
  function automatic int bit_cyc(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 8N1 receiver: 2-flop sync, start recheck, mid-bit sampling
module uart_rx_sampler
  import uart_echo_checker_pkg::*;
#(
  parameter int BIT_CYC = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rx_i,
  output logic                 rx_valid_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 frame_err_o
);

  localparam int CW   = $clog2(BIT_CYC + 1);
  localparam int HALF = BIT_CYC / 2;

  logic [1:0]           sync_q;
  logic                 prev_q;
  logic                 active_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           idx_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic [CW-1:0]        target_d;

  // Index 0 is the start bit, checked half a bit in; later samples are one bit apart.
  assign target_d = (idx_q == 4'd0) ? CW'(HALF - 1) : CW'(BIT_CYC - 1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      active_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= sync_q[1];
      valid_q <= 1'b0;
      if (!active_q) begin
        if (prev_q && !sync_q[1]) begin
          active_q <= 1'b1;
          cnt_q    <= '0;
          idx_q    <= '0;
        end
      end else if (cnt_q == target_d) begin
        cnt_q <= '0;
        if (idx_q == 4'd0) begin
          if (sync_q[1]) active_q <= 1'b0;
          else           idx_q    <= 4'd1;
        end else if (idx_q <= 4'(DATA_BITS)) begin
          data_q <= {sync_q[1], data_q[DATA_BITS-1:1]};
          idx_q  <= idx_q + 4'd1;
        end else begin
          valid_q  <= 1'b1;
          ferr_q   <= !sync_q[1];
          active_q <= 1'b0;
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign rx_valid_o  = valid_q;
  assign rx_data_o   = data_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_echo_checker.sv
// rtl/uart_echo_checker.sv - UART loopback self-test master: sends a byte ramp, checks echoes
module uart_echo_checker
  import uart_echo_checker_pkg::*;
#(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         BAUD         = 9600,
  parameter int         NUM_BYTES    = 16,
  parameter logic [7:0] SEED         = 8'h00,
  parameter int         TIMEOUT_BITS = 40
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rx,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [7:0] byte_cnt
);

  localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
  localparam int TMO_CYC = TIMEOUT_BITS * BIT_CYC;
  localparam int BW      = $clog2(BIT_CYC + 1);
  localparam int TW      = $clog2(TMO_CYC + 1);

  state_e        state_q;
  logic          tx_q, busy_q, done_q, pass_q;
  logic [7:0]    err_q, bcnt_q, byte_q;
  logic [BW-1:0] bit_cnt_q;
  logic [3:0]    bit_idx_q;
  logic [TW-1:0] tmo_q;
  logic          tmo_flag_q, got_q, rx_ferr_q;
  logic [7:0]    rx_byte_q;

  logic          rx_valid, rx_ferr;
  logic [7:0]    rx_data;
  logic [7:0]    err_inc_d, err_chk_d;
  logic          chk_err_d, next_bit_d;

  uart_rx_sampler #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk_i       (sys_clk),
    .rst_n_i     (rst_n),
    .rx_i        (rx),
    .rx_valid_o  (rx_valid),
    .rx_data_o   (rx_data),
    .frame_err_o (rx_ferr)
  );

  assign err_inc_d  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  // A timeout was already counted on expiry, so CHECK must not count it again.
  assign chk_err_d  = !tmo_flag_q && (rx_ferr_q || (rx_byte_q != byte_q));
  assign err_chk_d  = chk_err_d ? err_inc_d : err_q;
  assign next_bit_d = (bit_idx_q < 4'(DATA_BITS)) ? byte_q[bit_idx_q[2:0]] : 1'b1;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      bcnt_q     <= '0;
      byte_q     <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
      got_q      <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      done_q <= 1'b0;
      // The echo can complete while our own stop bit is still on the line.
      if ((state_q == ST_SEND || state_q == ST_WAIT_ECHO) && rx_valid && !got_q) begin
        got_q     <= 1'b1;
        rx_byte_q <= rx_data;
        rx_ferr_q <= rx_ferr;
      end
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (start) begin
            state_q   <= ST_SEND;
            busy_q    <= 1'b1;
            err_q     <= '0;
            bcnt_q    <= '0;
            pass_q    <= 1'b0;
            byte_q    <= SEED;
            tx_q      <= 1'b0;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            got_q     <= 1'b0;
          end
        end
        ST_SEND: begin
          if (bit_cnt_q == BW'(BIT_CYC - 1)) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 4'(FRAME_BITS - 1)) begin
              state_q    <= ST_WAIT_ECHO;
              bcnt_q     <= bcnt_q + 8'd1;
              tmo_q      <= '0;
              tmo_flag_q <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
              tx_q      <= next_bit_d;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BW'(1);
          end
        end
        ST_WAIT_ECHO: begin
          if (got_q) begin
            state_q <= ST_CHECK;
          end else if (tmo_q == TW'(TMO_CYC - 1)) begin
            tmo_flag_q <= 1'b1;
            err_q      <= err_inc_d;
            state_q    <= ST_CHECK;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_CHECK: begin
          err_q <= err_chk_d;
          if (bcnt_q == 8'(NUM_BYTES)) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
            pass_q  <= (err_chk_d == 8'd0);
          end else begin
            state_q   <= ST_SEND;
            byte_q    <= byte_q + 8'd1;
            tx_q      <= 1'b0;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            got_q     <= 1'b0;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign byte_cnt = bcnt_q;

endmodule

// File: tb/tb_uart_echo_checker.sv
// tb/tb_uart_echo_checker.sv - directed bench with tx-byte scoreboard for uart_echo_checker
module tb_uart_echo_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       rx_a, rx_b;
  logic       tx_a, busy_a, done_a, pass_a;
  logic       tx_b, busy_b, done_b, pass_b;
  logic [7:0] err_a, bcnt_a, err_b, bcnt_b;

  uart_echo_checker #(.CLK_FREQ(1_000_000), .BAUD(100_000), .NUM_BYTES(4),
                      .SEED(8'h30), .TIMEOUT_BITS(40)) dut_a (
    .sys_clk(clk), .rst_n(rst_n), .start(start_a), .rx(rx_a), .tx(tx_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .byte_cnt(bcnt_a));

  uart_echo_checker #(.CLK_FREQ(1_000_000), .BAUD(100_000), .NUM_BYTES(3),
                      .SEED(8'hFF), .TIMEOUT_BITS(40)) dut_b (
    .sys_clk(clk), .rst_n(rst_n), .start(start_b), .rx(rx_b), .tx(tx_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .byte_cnt(bcnt_b));

  int n_pass = 0, n_total = 0;
  logic [7:0] exp_q[$];
  logic mon_sel = 1'b0;
  int done_cnt_a = 0, done_cnt_b = 0;

  // Line corruption on dut_a's echo: 0 loopback, 1 stuck high, 2 flip bit3 of byte 1, 3 stop low on byte 0
  int rx_mode = 0;
  logic trk_act;
  int   trk_cyc;

  always @(posedge clk) begin
    if (!rst_n) begin
      trk_act <= 1'b0;
      trk_cyc <= 0;
    end else if (!trk_act) begin
      if (!tx_a) begin
        trk_act <= 1'b1;
        trk_cyc <= 1;
      end
    end else if (trk_cyc == 99) begin
      trk_act <= 1'b0;
    end else begin
      trk_cyc <= trk_cyc + 1;
    end
  end

  always_comb begin
    rx_a = tx_a;
    case (rx_mode)
      1: rx_a = 1'b1;
      2: rx_a = tx_a ^ (trk_act && bcnt_a == 8'd1 && trk_cyc >= 40 && trk_cyc < 50);
      3: rx_a = tx_a & !(trk_act && bcnt_a == 8'd0 && trk_cyc >= 90);
      default: rx_a = tx_a;
    endcase
  end
  assign rx_b = tx_b;

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Decode serial bytes on the selected tx and pop the scoreboard; frames cut by reset are dropped.
  initial begin
    logic [7:0] b;
    logic       abort;
    logic       mtx;
    forever begin
      @(negedge clk);
      mtx = mon_sel ? tx_b : tx_a;
      if (rst_n && mtx == 1'b0) begin
        abort = 1'b0;
        b = '0;
        for (int c = 0; c < 95; c++) begin
          @(negedge clk);
          mtx = mon_sel ? tx_b : tx_a;
          if (!rst_n) abort = 1'b1;
          if (c >= 14 && c <= 84 && (c - 14) % 10 == 0) b[(c - 14) / 10] = mtx;
        end
        if (!abort) begin
          check("tx_stop_bit", 32'(mtx), 32'd1);
          if (exp_q.size() == 0) check("tx_unexpected_byte", 32'(b), 32'hFFFF_FFFF);
          else                   check("tx_byte", 32'(b), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic start_run(input bit which, input logic [7:0] seed, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(8'(seed + 8'(k)));
    @(negedge clk);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("busy_after_start", 32'(which ? busy_b : busy_a), 32'd1);
    check("tx_start_bit", 32'(which ? tx_b : tx_a), 32'd0);
  endtask

  task automatic wait_done(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ((which ? done_b : done_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic run_a(input string tag, input int exp_err, input bit exp_pass);
    bit ok;
    int d0;
    d0 = done_cnt_a;
    start_run(1'b0, 8'h30, 4);
    wait_done(1'b0, ok);
    if (ok) begin
      check({tag, "_err_cnt"}, 32'(err_a), 32'(exp_err));
      check({tag, "_pass"}, 32'(pass_a), 32'(exp_pass));
      check({tag, "_byte_cnt"}, 32'(bcnt_a), 32'd4);
    end
    repeat (5) @(negedge clk);
    check({tag, "_busy_low"}, 32'(busy_a), 32'd0);
    check({tag, "_pass_held"}, 32'(pass_a), 32'(exp_pass));
    check({tag, "_done_once"}, 32'(done_cnt_a - d0), 32'd1);
    check({tag, "_all_tx_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    int d0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_err_cnt", 32'(err_a), 32'd0);
    check("rst_byte_cnt", 32'(bcnt_a), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    rx_mode = 0; run_a("loopback", 0, 1'b1);
    rx_mode = 1; run_a("timeout", 4, 1'b0);
    rx_mode = 2; run_a("bit3_flip", 1, 1'b0);
    rx_mode = 3; run_a("stop_low", 1, 1'b0);

    // Reset during the third data bit of byte 0
    rx_mode = 0;
    start_run(1'b0, 8'h30, 4);
    repeat (33) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx", 32'(tx_a), 32'd1);
    check("midrst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    d0 = done_cnt_a;
    repeat (200) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt_a - d0), 32'd0);
    check("midrst_byte_cnt", 32'(bcnt_a), 32'd0);
    run_a("after_rst", 0, 1'b1);

    // Seed wrap on dut_b, with a second start while busy
    mon_sel = 1'b1;
    repeat (3) @(negedge clk);
    d0 = done_cnt_b;
    start_run(1'b1, 8'hFF, 3);
    repeat (20) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_done(1'b1, ok);
    if (ok) begin
      check("wrap_err_cnt", 32'(err_b), 32'd0);
      check("wrap_pass", 32'(pass_b), 32'd1);
      check("wrap_byte_cnt", 32'(bcnt_b), 32'd3);
    end
    repeat (300) @(negedge clk);
    check("wrap_busy_low", 32'(busy_b), 32'd0);
    check("wrap_done_once", 32'(done_cnt_b - d0), 32'd1);
    check("wrap_all_tx_seen", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
